// File: rtl/jackpot_pkg.sv
// Shared types and constants for the jackpot switch-input block.
// Defines the handshake state type, switch count, debounce sizing and an arbiter helper.
package jackpot_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int NUM_SW           = 4;
  localparam int DEBOUNCE_DEFAULT = 1_250_000;
  localparam int CNT_W            = 22;

  // Lowest set bit wins, so simultaneous presses drain in ascending order.
  function automatic logic [1:0] lowest_index(input logic [NUM_SW-1:0] v);
    lowest_index = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = 2'(i);
    end
  endfunction

endpackage

// File: rtl/jackpot_input_sw_debounce.sv
// Per-switch synchronizer, debounce counter, stable level register and rise pulse.
// Latency: stable follows a clean raw edge after 2+DEBOUNCE_CYCLES cycles; rise pulses with it.
// Backpressure: none; rise is a single-cycle pulse consumed by the parent arbiter.
module sw_debounce
  import jackpot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [1:0]       fill;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // A switch must be seen low once the synchronizer holds real data before a
  // rise may count, so a switch held through reset yields no press event.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      fill   <= 2'b00;
      armed  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      rise  <= 1'b0;
      if (fill[1] && !sync2 && !stable) armed <= 1'b1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt    <= '0;
        stable <= ~stable;
        rise   <= ~stable & armed;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/jackpot_input.sv
// Debounced switch inputs turned into press events for the game core (OVERRUN under JACKPOT_INPUT_OVERRUN_EN).
// Latency: PRESS_VALID rises one cycle after the STABLE_SW rise; one idle cycle between events.
// Backpressure: PRESS_INDEX holds until PRESS_READY; one pending slot per switch, repeats merge.
module jackpot_input
  import jackpot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [NUM_SW-1:0] SWITCHES,
  output logic [NUM_SW-1:0] STABLE_SW,
  output logic              PRESS_VALID,
  output logic [1:0]        PRESS_INDEX,
  input  logic              PRESS_READY
`ifdef JACKPOT_INPUT_OVERRUN_EN
  ,
  output logic              OVERRUN
`endif
);

  state_t            state;
  logic [NUM_SW-1:0] rise;
  logic [NUM_SW-1:0] pending;
  logic [NUM_SW-1:0] pend_eff;
  logic [NUM_SW-1:0] clr_mask;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .raw    (SWITCHES[i]),
      .stable (STABLE_SW[i]),
      .rise   (rise[i])
    );
  end

  // Rises are visible to the arbiter in the cycle they occur.
  always_comb begin
    pend_eff = pending | rise;
    clr_mask = '0;
    if (state == OFFER && PRESS_READY) clr_mask[PRESS_INDEX] = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= IDLE;
      PRESS_VALID <= 1'b0;
      PRESS_INDEX <= '0;
      pending     <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | rise;
      case (state)
        IDLE: begin
          if (|pend_eff) begin
            PRESS_INDEX <= lowest_index(pend_eff);
            PRESS_VALID <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (PRESS_READY) begin
            PRESS_VALID <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          PRESS_VALID <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef JACKPOT_INPUT_OVERRUN_EN
  // A rise racing the transfer of the same bit simply re-arms it, so it is not an overrun.
  always_ff @(posedge CLOCK) begin
    if (RESET) OVERRUN <= 1'b0;
    else if (|(rise & pending & ~clr_mask)) OVERRUN <= 1'b1;
  end
`else
  // Repeated presses on a pending switch merge silently.
`endif

endmodule
